// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode constants, instruction-word field bounds and fetch-state encoding.
// Fetch, control and later pipeline stages all import this package.
package isa_pkg;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 7;

  localparam logic [15:0] NOP_WORD = 16'h0000;

  localparam logic [8:0] OP_NOP  = 9'b000_00000;
  localparam logic [8:0] OP_SETC = 9'b000_00001;
  localparam logic [8:0] OP_NOT  = 9'b001_00000;
  localparam logic [8:0] OP_INC  = 9'b001_00001;
  localparam logic [8:0] OP_OUT  = 9'b001_00010;
  localparam logic [8:0] OP_IN   = 9'b001_00011;
  localparam logic [8:0] OP_MOV  = 9'b010_00000;
  localparam logic [8:0] OP_ADD  = 9'b010_00001;
  localparam logic [8:0] OP_SUB  = 9'b010_00010;
  localparam logic [8:0] OP_AND  = 9'b010_00011;
  localparam logic [8:0] OP_PUSH = 9'b011_00000;
  localparam logic [8:0] OP_POP  = 9'b011_00001;
  localparam logic [8:0] OP_LDM  = 9'b011_00010;
  localparam logic [8:0] OP_LDD  = 9'b011_00011;
  localparam logic [8:0] OP_STD  = 9'b011_00100;
  localparam logic [8:0] OP_JZ   = 9'b100_00000;
  localparam logic [8:0] OP_JN   = 9'b100_00001;
  localparam logic [8:0] OP_JC   = 9'b100_00010;
  localparam logic [8:0] OP_JMP  = 9'b100_00011;
  localparam logic [8:0] OP_CALL = 9'b100_00100;
  localparam logic [8:0] OP_RET  = 9'b100_00101;

  typedef enum logic {
    FETCH = 1'b0,
    IMM   = 1'b1
  } fetch_state_t;

  // Only the memory-immediate forms carry a second word; undefined opcodes are one word.
  function automatic logic is_two_word(input logic [8:0] opcode);
    return (opcode == OP_LDM) || (opcode == OP_LDD) || (opcode == OP_STD);
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: load beats increment, otherwise hold; async reset to RESET_PC.
module pc_reg #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [PC_W-1:0] pc_reg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg_q <= RESET_PC;
    end else if (load) begin
      pc_reg_q <= load_val;
    end else if (inc) begin
      pc_reg_q <= pc_reg_q + PC_ONE;
    end
  end

  assign pc = pc_reg_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch with one/two-word assembly and the IF/ID pipeline register.
// A two-word instruction inserts one bubble while its immediate is fetched.
module fetch_stage
  import isa_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic [15:0]     if_id_instr,
  output logic [15:0]     if_id_imm,
  output logic [PC_W-1:0] if_id_pc,
  output logic [PC_W-1:0] if_id_pc_next,
  output logic            if_id_valid
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus_one;
  fetch_state_t    state_reg;
  logic [15:0]     hold_instr_reg;
  logic [PC_W-1:0] hold_pc_reg;
  logic [15:0]     instr_reg;
  logic [15:0]     imm_reg;
  logic [PC_W-1:0] id_pc_reg;
  logic [PC_W-1:0] id_pc_next_reg;
  logic            valid_reg;

  pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (branch_taken),
    .load_val (branch_target),
    .inc      (!stall && !branch_taken),
    .pc       (pc)
  );

  assign pc_plus_one = pc + PC_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= FETCH;
      hold_instr_reg <= '0;
      hold_pc_reg    <= '0;
      instr_reg      <= NOP_WORD;
      imm_reg        <= '0;
      id_pc_reg      <= '0;
      id_pc_next_reg <= '0;
      valid_reg      <= 1'b0;
    end else if (branch_taken) begin
      // Redirect squashes whatever half-assembled instruction is in flight.
      state_reg      <= FETCH;
      hold_instr_reg <= '0;
      hold_pc_reg    <= '0;
      instr_reg      <= NOP_WORD;
      imm_reg        <= '0;
      valid_reg      <= 1'b0;
    end else if (!stall) begin
      case (state_reg)
        FETCH: begin
          if (is_two_word(imem_data[OPC_HI:OPC_LO])) begin
            hold_instr_reg <= imem_data;
            hold_pc_reg    <= pc;
            instr_reg      <= NOP_WORD;
            imm_reg        <= '0;
            valid_reg      <= 1'b0;
            state_reg      <= IMM;
          end else begin
            instr_reg      <= imem_data;
            imm_reg        <= '0;
            id_pc_reg      <= pc;
            id_pc_next_reg <= pc_plus_one;
            valid_reg      <= 1'b1;
          end
        end
        IMM: begin
          instr_reg      <= hold_instr_reg;
          imm_reg        <= imem_data;
          id_pc_reg      <= hold_pc_reg;
          id_pc_next_reg <= pc_plus_one;
          valid_reg      <= 1'b1;
          state_reg      <= FETCH;
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

  assign imem_addr     = pc;
  assign if_id_instr   = instr_reg;
  assign if_id_imm     = imm_reg;
  assign if_id_pc      = id_pc_reg;
  assign if_id_pc_next = id_pc_next_reg;
  assign if_id_valid   = valid_reg;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage processor. Drives the instruction-memory address, assembles one- and two-word instructions, and presents each decoded-ready instruction word plus its immediate to the decode stage. The 9-bit opcode field of the registered word feeds the control unit directly. Handles stalls from hazard detection and redirects from taken branches, CALL and RET.

## Interface
- `PC_W`, default 32: program-counter and instruction-address width.
- `RESET_PC`, default 0: PC value loaded on reset.
- `clk` in 1: system clock, rising-edge active.
- `rst` in 1: asynchronous, active-high reset.
- `imem_addr` out `PC_W`: instruction-memory address, equal to the current PC.
- `imem_data` in 16: instruction word at `imem_addr`, combinational, valid in the same cycle.
- `stall` in 1: hold PC, state and IF/ID contents.
- `branch_taken` in 1: redirect fetch to `branch_target` and squash the in-flight fetch.
- `branch_target` in `PC_W`: redirect address.
- `if_id_instr` out 16: registered instruction word. Opcode is `[15:7]`, Rsrc is `[6:4]`, Rdst is `[3:1]`, bit 0 is unused.
- `if_id_imm` out 16: registered second word of a two-word instruction; 0 otherwise.
- `if_id_pc` out `PC_W`: address of the first word of `if_id_instr`.
- `if_id_pc_next` out `PC_W`: address following the complete instruction; CALL uses it as the return address.
- `if_id_valid` out 1: the IF/ID register holds a real instruction. When 0, `if_id_instr` is the NOP word `16'h0000`.

## Operation
- Two-word opcodes are LDM `9'b011_00010`, LDD `9'b011_00011` and STD `9'b011_00100`. Every other opcode, including undefined ones, is one word.
- **State FETCH**, not stalled, no branch:
  - One-word opcode in `imem_data[15:7]`:
    - Load IF/ID with instr=`imem_data`, imm=0, pc=PC, pc_next=PC+1, valid=1.
    - PC becomes PC+1.
  - Two-word opcode:
    - Latch `imem_data` and PC into a hold register.
    - Load IF/ID with a bubble (valid=0, instr=0, imm=0).
    - PC becomes PC+1; go to IMM.
- **State IMM**, not stalled, no branch:
  - Load IF/ID with instr=held word, imm=`imem_data`, pc=held PC, pc_next=PC+1, valid=1.
  - PC becomes PC+1; go to FETCH.
- **branch_taken** (highest priority after reset; overrides `stall`):
  - PC becomes `branch_target`.
  - IF/ID becomes a bubble.
  - The hold register is discarded; state becomes FETCH.
- **stall** without branch: PC, state, hold register and all IF/ID outputs keep their values. `imem_addr` stays on the held PC.
- PC arithmetic is modulo 2^`PC_W`; all-ones wraps to 0.
- The word fetched in IMM is never opcode-decoded.
- **Reset**, asynchronous at any time including mid-IMM:
  - PC=`RESET_PC`, state=FETCH, hold register=0.
  - `if_id_instr`=0, `if_id_imm`=0, `if_id_pc`=0, `if_id_pc_next`=0, `if_id_valid`=0.

## Timing
- `imem_addr` is combinational from the PC register and changes only after a clock edge or reset.
- One-word instruction at address A: with PC=A in cycle n, it appears on IF/ID outputs after the edge ending cycle n. Latency is 1 cycle, throughput is 1 per cycle.
- Two-word instruction at address A: the bubble appears after edge n and the full instruction after edge n+1. Latency is 2 cycles; one bubble is inserted.
- A redirect asserted in cycle n makes PC=`branch_target` in cycle n+1. The IF/ID output after edge n is a bubble.
- `stall` and `branch_taken` are sampled only at rising edges and are level-sensitive. There is no handshake beyond `stall`.

## Structure
- Shared package `isa_pkg` holds:
  - 9-bit opcode constants for all instructions.
  - `NOP_WORD` = `16'h0000`.
  - Opcode field bounds `[15:7]`.
  - Function `is_two_word(opcode)`.
  - Fetch-state enum {FETCH, IMM}.
  - The CU and later stages reuse the same opcode constants.
- One sub-module, `pc_reg`: PC register with load, increment and hold controls, async reset to `RESET_PC`.
- The state machine, hold register and IF/ID register stay in `fetch_stage`.

## Test plan
- **Reset and sequential fetch.** Memory is 0:`16'h0000` (NOP), 1:`INC R1`, 2:`ADD R1,R2`; release reset.
  - `imem_addr` steps 0,1,2.
  - IF/ID shows pc=0,1,2 with valid=1.
  - The INC word has opcode `9'b001_00001`.
- **Two-word LDM.** Address 4 holds LDM R3 and address 5 holds `16'h1234`.
  - One bubble (valid=0) appears first.
  - Next cycle: instr=LDM word, imm=`16'h1234`, pc=4, pc_next=6.
- **Stall.** Hold `stall`=1 for 3 cycles, both mid-stream in FETCH and in IMM.
  - PC and all IF/ID outputs are unchanged.
  - On release, the LDM completes with the correct immediate.
- **Branch during IMM, with stall also high.** Issue the LDM at 8, then assert `branch_taken`, target=`32'h20`, in the IMM cycle.
  - Next IF/ID is a bubble, PC=`32'h20`.
  - The LDM is never emitted with valid=1.
- **Asynchronous reset mid-IMM and PC wrap.** Assert `rst` between edges while in IMM.
  - All outputs go to 0 immediately and PC returns to `RESET_PC`.
  - Then branch to all-ones (`32'hFFFF_FFFF`) holding a one-word opcode: `if_id_pc_next`=0 and PC=0.
